// File: rtl/qrisc32_id_gen.sv
// qrisc32 decode / register-read stage: register file with NWB forwarding writeback
// ports, valid/ready handshake, load-use interlock, flush and saturating counters.
module qrisc32_id_gen #(
   parameter int DW      = 32,
   parameter int NREG    = 32,
   parameter int NWB     = 2,
   parameter int ZERO_R0 = 0,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DW-1:0]     in_pc,
   input  logic              flush,
   input  logic [NWB-1:0]    wb_en,
   input  logic [5*NWB-1:0]  wb_addr,
   input  logic [DW*NWB-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_op,
   output logic [2:0]        out_sub,
   output logic [4:0]        out_dst,
   output logic [4:0]        out_src1,
   output logic [4:0]        out_src2,
   output logic [DW-1:0]     out_val_r1,
   output logic [DW-1:0]     out_val_r2,
   output logic [DW-1:0]     out_val_dst,
   output logic              out_write_reg,
   output logic              out_read_mem,
   output logic              out_write_mem,
   output logic              out_illegal,
   output logic [CNT_W-1:0]  cnt_nop,
   output logic [CNT_W-1:0]  cnt_jmp,
   output logic [CNT_W-1:0]  cnt_alu,
   output logic [CNT_W-1:0]  cnt_oth,
   output logic [CNT_W-1:0]  cnt_stall
);

   localparam logic [3:0] OP_LDR    = 4'd0;
   localparam logic [3:0] OP_STR    = 4'd1;
   localparam logic [3:0] OP_JMPUNC = 4'd2;
   localparam logic [3:0] OP_JMPF   = 4'd3;
   localparam logic [3:0] OP_ALU    = 4'd4;
   localparam logic [3:0] OP_LDRF   = 4'd5;
   localparam int HW = DW / 2;
   localparam int UW = DW - HW;

   logic [DW-1:0] rf [0:31];
   logic          vld_p1;

   logic [3:0]    f_op;
   logic [4:0]    f_dst, f_src1, f_src2;
   logic          hazard, accept;
   logic [DW-1:0] rv_r1, rv_r2, rv_dst, imm;
   logic signed [DW-1:0] imm_sx;
   logic [DW-1:0] d_r1, d_r2, d_dst;
   logic          d_wr, d_rm, d_wm, d_ill;
   logic          c_nop, c_jmp, c_alu, c_oth;

   assign f_op   = in_instr[31:28];
   assign f_dst  = in_instr[4:0];
   assign f_src1 = in_instr[9:5];
   assign f_src2 = in_instr[14:10];
   assign imm_sx = {{(DW-15){in_instr[24]}}, in_instr[24:10]};

   assign out_valid = vld_p1;
   assign hazard = vld_p1 && out_read_mem &&
                   (out_dst == f_src1 || out_dst == f_src2 || out_dst == f_dst) &&
                   (ZERO_R0 == 0 || out_dst != 5'd0);
   assign in_ready = !hazard && (!vld_p1 || out_ready);
   assign accept   = in_valid && in_ready;

   // Register read with bypass; the highest-index enabled port matching wins.
   function automatic logic [DW-1:0] rd_op(input logic [4:0] a);
      logic [DW-1:0] v;
      v = '0;
      if (int'(a) < NREG && !(ZERO_R0 != 0 && a == 5'd0)) begin
         v = rf[a];
         for (int i = 0; i < NWB; i++)
            if (wb_en[i] && wb_addr[5*i +: 5] == a) v = wb_data[DW*i +: DW];
      end
      return v;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   always_comb begin
      rv_r1  = rd_op(f_src1);
      rv_r2  = rd_op(f_src2);
      rv_dst = rd_op(f_dst);
      imm    = in_instr[25] ? rv_r2 : imm_sx;
      d_r1   = rv_r1;
      d_r2   = rv_r2;
      d_dst  = rv_dst;
      d_wr   = 1'b0;
      d_rm   = 1'b0;
      d_wm   = 1'b0;
      d_ill  = 1'b0;
      case (f_op)
         OP_LDR:
            case (in_instr[27:26])
               2'b00: begin d_dst = rv_r1; d_wr = (f_dst != f_src1); end
               2'b01: begin d_dst = {UW'(in_instr[20:5]), rv_dst[HW-1:0]}; d_wr = 1'b1; end
               2'b10: begin d_dst = {rv_dst[DW-1:HW], HW'(in_instr[20:5])}; d_wr = 1'b1; end
               default: begin d_rm = 1'b1; d_wr = 1'b1; d_r2 = imm; end
            endcase
         OP_STR: begin d_wm = 1'b1; d_r2 = imm; end
         OP_JMPUNC:
            case (in_instr[27:26])
               2'b00: begin d_r1 = DW'(in_instr[25:0]); d_r2 = '0; end
               2'b01: begin d_r1 = in_pc; d_r2 = imm; end
               2'b10: begin d_r1 = in_pc; d_r2 = imm; d_dst = in_pc; d_wr = 1'b1; end
               default: begin d_r1 = rv_dst; d_r2 = '0; end
            endcase
         OP_JMPF: begin d_r1 = in_pc; d_r2 = imm; end
         OP_ALU:  d_wr = (in_instr[27:25] != 3'd7);
         OP_LDRF: d_wr = 1'b1;
         default: d_ill = 1'b1;
      endcase
   end

   always_comb begin
      c_nop = (in_instr == 32'd0);
      c_jmp = !c_nop && (f_op == OP_JMPUNC || f_op == OP_JMPF);
      c_alu = !c_nop && (f_op == OP_ALU);
      c_oth = !c_nop && !c_jmp && !c_alu;
   end

   // Stage p1: decoded bundle, register-file update and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < 32; r++) rf[r] <= '0;
         vld_p1        <= 1'b0;
         out_op        <= '0;
         out_sub       <= '0;
         out_dst       <= '0;
         out_src1      <= '0;
         out_src2      <= '0;
         out_val_r1    <= '0;
         out_val_r2    <= '0;
         out_val_dst   <= '0;
         out_write_reg <= 1'b0;
         out_read_mem  <= 1'b0;
         out_write_mem <= 1'b0;
         out_illegal   <= 1'b0;
         cnt_nop       <= '0;
         cnt_jmp       <= '0;
         cnt_alu       <= '0;
         cnt_oth       <= '0;
         cnt_stall     <= '0;
      end else begin
         for (int i = 0; i < NWB; i++)
            if (wb_en[i] && int'(wb_addr[5*i +: 5]) < NREG &&
                !(ZERO_R0 != 0 && wb_addr[5*i +: 5] == 5'd0))
               rf[wb_addr[5*i +: 5]] <= wb_data[DW*i +: DW];
         if (in_valid && !in_ready) cnt_stall <= sat_inc(cnt_stall);
         if (flush) begin
            vld_p1 <= 1'b0;
         end else if (accept) begin
            vld_p1        <= 1'b1;
            out_op        <= f_op;
            out_sub       <= in_instr[27:25];
            out_dst       <= f_dst;
            out_src1      <= f_src1;
            out_src2      <= f_src2;
            out_val_r1    <= d_r1;
            out_val_r2    <= d_r2;
            out_val_dst   <= d_dst;
            out_write_reg <= d_wr;
            out_read_mem  <= d_rm;
            out_write_mem <= d_wm;
            out_illegal   <= d_ill;
            if (c_nop) cnt_nop <= sat_inc(cnt_nop);
            if (c_jmp) cnt_jmp <= sat_inc(cnt_jmp);
            if (c_alu) cnt_alu <= sat_inc(cnt_alu);
            if (c_oth) cnt_oth <= sat_inc(cnt_oth);
         end else if (out_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

endmodule
